pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 24 ++
 rtl/pipe_adder_slice.sv | 14 +
 rtl/pipe_adder.sv | 123 ++++++++++++
 tb/tb_pipe_adder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants, chunk sizing and the stage-register layout for pipe_adder.
// Operand fields are sized for the widest supported adder; narrower builds leave the upper bits zero.
package pipe_adder_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 2;
   localparam int MAX_WIDTH  = 64;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   // One pipeline slot: psum accumulates one chunk per stage while a/b carry the
   // not-yet-added upper chunks forward so every stage sees aligned operands.
   typedef struct packed {
      logic                 valid;
      logic [MAX_WIDTH-1:0] psum;
      logic                 carry;
      logic [MAX_WIDTH-1:0] a;
      logic [MAX_WIDTH-1:0] b;
      logic                 op_sub;
   } stage_t;

endpackage

// File: rtl/pipe_adder_slice.sv
// adder_slice: one chunk-wide combinational adder with carry in and carry out.
module adder_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep chunked ripple adder with valid/ready flow control on both sides.
// Define PIPE_ADDER_SUB_EN to add an op_sub input selecting a - b (computed as a + ~b + 1).
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             op_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s
);

   // Handshake: a beat moves when valid && ready on the same rising edge; valid never
   // waits on ready, and in_ready depends only on stage state and out_ready.

   localparam int CW = chunk_width(WIDTH, STAGES);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
      $error("pipe_adder: WIDTH must be 2..%0d and divisible by STAGES", MAX_WIDTH);
   end

   logic                   op_sub_w;
   logic [WIDTH-1:0]       b_eff;
   logic                   init_q;
   logic [STAGES-1:0]      en;
   stage_t                 stage_q [STAGES];
   stage_t                 stage_d [STAGES];
   logic [STAGES-1:0][CW-1:0] ca;
   logic [STAGES-1:0][CW-1:0] cb;
   logic [STAGES-1:0][CW-1:0] csum;
   logic [STAGES-1:0]      cin;
   logic [STAGES-1:0]      cout;

`ifdef PIPE_ADDER_SUB_EN
   assign op_sub_w = op_sub;
`else
   assign op_sub_w = 1'b0;
`endif

   assign b_eff = op_sub_w ? ~b : b;

   // A stage may load when it is empty or its content leaves this same cycle.
   always_comb begin
      en = '0;
      en[STAGES-1] = !stage_q[STAGES-1].valid || out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         en[k] = !stage_q[k].valid || en[k+1];
      end
   end

   assign in_ready  = init_q && en[0];
   assign out_valid = stage_q[STAGES-1].valid;
   assign s         = {stage_q[STAGES-1].carry, stage_q[STAGES-1].psum[WIDTH-1:0]};

   always_comb begin
      ca  = '0;
      cb  = '0;
      cin = '0;
      ca[0]  = a[CW-1:0];
      cb[0]  = b_eff[CW-1:0];
      cin[0] = op_sub_w;
      for (int k = 1; k < STAGES; k++) begin
         ca[k]  = stage_q[k-1].a[k*CW +: CW];
         cb[k]  = stage_q[k-1].b[k*CW +: CW];
         cin[k] = stage_q[k-1].carry;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      adder_slice #(
         .W(CW)
      ) u_slice (
         .a   (ca[k]),
         .b   (cb[k]),
         .cin (cin[k]),
         .sum (csum[k]),
         .cout(cout[k])
      );
   end

   // Stage k inherits everything from stage k-1 and fills in its own sum chunk.
   always_comb begin
      stage_d[0]                  = '0;
      stage_d[0].valid            = in_valid;
      stage_d[0].psum[CW-1:0]     = csum[0];
      stage_d[0].carry            = cout[0];
      stage_d[0].a[WIDTH-1:0]     = a;
      stage_d[0].b[WIDTH-1:0]     = b_eff;
      stage_d[0].op_sub           = op_sub_w;
      for (int k = 1; k < STAGES; k++) begin
         stage_d[k]                   = stage_q[k-1];
         stage_d[k].psum[k*CW +: CW]  = csum[k];
         stage_d[k].carry             = cout[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         init_q <= 1'b1;
         for (int k = 0; k < STAGES; k++) begin
            if (en[k]) begin
               stage_q[k] <= stage_d[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and random checks of pipe_adder against an arithmetic reference model.
// With PIPE_ADDER_SUB_EN defined the bench runs WIDTH=16, STAGES=4 and adds subtract cases.
module tb_pipe_adder;

`ifdef PIPE_ADDER_SUB_EN
   localparam int W = 16;
   localparam int S = 4;
`else
   localparam int W = 8;
   localparam int S = 2;
`endif
   localparam int W1 = W + 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         op_sub = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W:0]   s;

   int n_assert = 0;
   int n_fail   = 0;
   int step_no  = 0;
   int n_in     = 0;
   int n_out    = 0;
   bit last_acc = 1'b0;
   bit lat_chk  = 1'b0;

   logic [W:0] exp_q[$];
   int         acc_q[$];

   always #5 clk = ~clk;

   pipe_adder #(
      .WIDTH (W),
      .STAGES(S)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
`ifdef PIPE_ADDER_SUB_EN
      .op_sub   (op_sub),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s)
   );

   // Reference: plain integer arithmetic; subtraction reports "no borrow" in the MSB.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sub);
      longint ux = longint'(x);
      longint uy = longint'(y);
      longint m  = longint'(1) << W;
      if (!sub) return W1'(ux + uy);
      if (ux >= uy) return W1'(m + (ux - uy));
      return W1'((ux - uy + m) % m);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: sample both handshakes at the falling edge, then move past the rising edge.
   task automatic step();
      logic [W:0] e;
      int         t;
      @(negedge clk);
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         exp_q.push_back(ref_sum(a, b, op_sub));
         acc_q.push_back(step_no);
         n_in++;
      end
      if (out_valid && out_ready) begin
         n_out++;
         check("output_not_spurious", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            check("sum", 64'(s), 64'(e));
            if (lat_chk) check("latency", 64'(step_no - t), 64'(S));
         end
      end
      @(posedge clk);
      #1;
      step_no++;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
      int n = 0;
      a = x;
      b = y;
      op_sub = sub;
      in_valid = 1'b1;
      do begin
         step();
         n++;
      end while (!last_acc && n < 50);
      check("accept_in_time", 64'(last_acc), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input logic [W:0] lit);
      int n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      check("out_valid_in_time", 64'(out_valid), 64'd1);
      check(tag, 64'(s), 64'(lit));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [W-1:0] maxv;
      logic [W-1:0] bp_a[4];
      logic [W-1:0] bp_b[4];
      logic [W:0]   s_hold;
      int           n0;
      int           idx;
      int           n;

      maxv = '1;
      s_hold = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_s", 64'(s), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_release", 64'(in_ready), 64'd1);

      // Basic adds with exact latency
      out_ready = 1'b1;
      lat_chk = 1'b1;
      send(W'(5), W'(7), 1'b0);
      wait_out("add_5_7", W1'(12));
      drain();
      send(W'(100), W'(28), 1'b0);
      wait_out("add_100_28", W1'(128));
      drain();

      // Boundary sums
      send(maxv, maxv, 1'b0);
      wait_out("add_max_max", W1'(maxv) << 1);
      drain();
      send(maxv, W'(1), 1'b0);
      wait_out("add_max_1", W1'(1) << W);
      drain();
      send(W'(0), W'(0), 1'b0);
      wait_out("add_0_0", W1'(0));
      drain();

      // Throughput: back-to-back random pairs, one result per cycle
      n0 = n_out;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom);
         b = W'($urandom);
`ifdef PIPE_ADDER_SUB_EN
         op_sub = 1'($urandom_range(0, 1));
`else
         op_sub = 1'b0;
`endif
         check("tp_in_ready", 64'(in_ready), 64'd1);
         step();
      end
      in_valid = 1'b0;
      op_sub = 1'b0;
      repeat (S) step();
      check("tp_result_count", 64'(n_out - n0), 64'd10);
      check("tp_queue_empty", 64'(exp_q.size()), 64'd0);
      lat_chk = 1'b0;

      // Back-pressure: stall the consumer while offering four pairs
      for (int i = 0; i < 4; i++) begin
         bp_a[i] = W'($urandom);
         bp_b[i] = W'($urandom);
      end
      n0 = n_out;
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin
            a = bp_a[idx];
            b = bp_b[idx];
         end
         step();
         if (last_acc) idx++;
         if (c == S - 1) s_hold = s;
      end
      check("bp_accepted", 64'(idx), 64'((S < 4) ? S : 4));
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid_held", 64'(out_valid), 64'd1);
      check("bp_s_stable", 64'(s), 64'(s_hold));
      check("bp_s_head", 64'(s), 64'(exp_q[0]));
      out_ready = 1'b1;
      n = 0;
      while (idx < 4 && n < 50) begin
         in_valid = 1'b1;
         a = bp_a[idx];
         b = bp_b[idx];
         step();
         if (last_acc) idx++;
         n++;
      end
      in_valid = 1'b0;
      drain();
      check("bp_all_results", 64'(n_out - n0), 64'd4);

`ifdef PIPE_ADDER_SUB_EN
      // Subtract mode
      lat_chk = 1'b1;
      send(W'(5), W'(7), 1'b1);
      wait_out("sub_5_7", 17'h0FFFE);
      drain();
      send(W'(7), W'(5), 1'b1);
      wait_out("sub_7_5", 17'h10002);
      drain();
      send(maxv, maxv, 1'b1);
      drain();
      lat_chk = 1'b0;
`endif

      // Reset with two results in flight
      send(W'($urandom), W'($urandom), 1'b0);
      send(W'($urandom), W'($urandom), 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_s", 64'(s), 64'd0);
      exp_q.delete();
      acc_q.delete();
      n_in = 0;
      n_out = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_ready_after_release", 64'(in_ready), 64'd1);
      for (int i = 0; i < 2 * S + 2; i++) begin
         check("no_stale_output", 64'(out_valid), 64'd0);
         step();
      end
      check("no_stale_count", 64'(n_out), 64'd0);

      // Pipeline still works after the reset
      lat_chk = 1'b1;
      send(W'(100), W'(28), 1'b0);
      wait_out("post_reset_add", W1'(128));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
